// File: rtl/int_mult_pkg.sv
// Shared definitions for the FFT/NTT multiplier-pool arbiter and the pool wrapper.
// Holds the grant-state encoding, the default pool latency and the result tag layout.
package int_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FFT  = 2'd1,
        NTT  = 2'd2
    } arb_state_e;

    localparam int MULT_LATENCY_DEFAULT = 6;
    localparam int BURST_W              = 8;

    // One tag per in-flight pool slot: which client the eventual result belongs to.
    typedef struct packed {
        logic fft;
        logic ntt;
    } res_tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Ownership tags travelling alongside the multiplier pipeline; the tag leaving the
// last stage marks which client the pool result belongs to.
module tag_delay_line
    import int_mult_pkg::*;
#(
    parameter int DEPTH = MULT_LATENCY_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  res_tag_t tag_in,
    output res_tag_t tag_out,
    output logic     busy
);

    res_tag_t [DEPTH-1:0] vld_pipe_q;
    res_tag_t [DEPTH-1:0] vld_pipe_d;

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // Clearing every stage on reset is what discards in-flight operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign tag_out = vld_pipe_q[DEPTH-1];
    assign busy    = |vld_pipe_q;

endmodule

// File: rtl/int_mult_arbiter.sv
// Two-client (FFT/NTT) arbiter for a shared pipelined multiplier pool with
// burst-limited fairness and result-ownership tracking.
module int_mult_arbiter
    import int_mult_pkg::*;
#(
    parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT,
    parameter int MAX_BURST    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fft_req,
    input  logic fft_issue,
    input  logic ntt_req,
    input  logic ntt_issue,
    output logic grant_to_fft,
    output logic fft_gnt,
    output logic ntt_gnt,
    output logic fft_res_valid,
    output logic ntt_res_valid,
    output logic busy,
    output logic protocol_err
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               prefer_fft_q, prefer_fft_d;
    logic               grant_q, grant_d;
    logic               perr_q, perr_d;

    logic     fft_own, ntt_own;
    res_tag_t tag_in, tag_out;
    logic     line_busy;

    assign fft_own = (state_q == FFT);
    assign ntt_own = (state_q == NTT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fft_req && ntt_req) begin
                    state_d = prefer_fft_q ? FFT : NTT;
                end else if (fft_req) begin
                    state_d = FFT;
                end else if (ntt_req) begin
                    state_d = NTT;
                end
            end
            FFT: begin
                if (!fft_req) begin
                    state_d = ntt_req ? NTT : IDLE;
                end else if (ntt_req && burst_cnt_q == BURST_LAST) begin
                    state_d = NTT;
                end
            end
            NTT: begin
                if (!ntt_req) begin
                    state_d = fft_req ? FFT : IDLE;
                end else if (fft_req && burst_cnt_q == BURST_LAST) begin
                    state_d = FFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_d != state_q) begin
            burst_cnt_d = '0;
        end else if (state_q != IDLE && burst_cnt_q != BURST_LAST) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    // The client served this cycle loses priority at the next two-way tie in IDLE.
    always_comb begin
        prefer_fft_d = prefer_fft_q;
        if (fft_own) begin
            prefer_fft_d = 1'b0;
        end else if (ntt_own) begin
            prefer_fft_d = 1'b1;
        end
    end

    // Mux select follows the next owner so it lines up with the registered grant;
    // in IDLE it keeps pointing at whoever had the pool last.
    always_comb begin
        grant_d = grant_q;
        if (state_d == FFT) begin
            grant_d = 1'b1;
        end else if (state_d == NTT) begin
            grant_d = 1'b0;
        end
    end

    always_comb begin
        perr_d = perr_q | (fft_issue & ~fft_own) | (ntt_issue & ~ntt_own);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            prefer_fft_q <= 1'b1;
            grant_q      <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            prefer_fft_q <= prefer_fft_d;
            grant_q      <= grant_d;
            perr_q       <= perr_d;
        end
    end

    // Only issues from the current owner enter the pipeline; the rest are dropped.
    assign tag_in.fft = fft_issue & fft_own;
    assign tag_in.ntt = ntt_issue & ntt_own;

    tag_delay_line #(
        .DEPTH (MULT_LATENCY)
    ) u_tag_delay_line (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .busy    (line_busy)
    );

    // Outputs are forced to their reset values while rst is held, including the
    // first reset cycle before the registers have cleared.
    assign grant_to_fft  = grant_q & ~rst;
    assign fft_gnt       = fft_own & ~rst;
    assign ntt_gnt       = ntt_own & ~rst;
    assign fft_res_valid = tag_out.fft & ~rst;
    assign ntt_res_valid = tag_out.ntt & ~rst;
    assign busy          = line_busy & ~rst;
    assign protocol_err  = perr_q & ~rst;

endmodule

// File: doc/int_mult_arbiter.md
INT_MULT_ARBITER -- requirements
Module: int_mult_arbiter

Interface
REQ-001 Parameter MULT_LATENCY, default 6: pipeline depth, cycles from operands presented to result valid.
REQ-002 Parameter MAX_BURST, default 4: max consecutive granted cycles while the other client waits; legal range 1..255.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fft_req  in  1  FFT client wants the multiplier pool.
REQ-006 fft_issue  in  1  FFT operands valid on pool inputs this cycle.
REQ-007 ntt_req  in  1  NTT client wants the multiplier pool.
REQ-008 ntt_issue  in  1  NTT operands valid on pool inputs this cycle.
REQ-009 grant_to_fft  out  1  operand-mux select driving the pool's grant_to_fft input.
REQ-010 fft_gnt  out  1  FFT owns the pool this cycle.
REQ-011 ntt_gnt  out  1  NTT owns the pool this cycle.
REQ-012 fft_res_valid  out  1  pool result belongs to FFT this cycle.
REQ-013 ntt_res_valid  out  1  pool result belongs to NTT this cycle.
REQ-014 busy  out  1  at least one accepted operation in flight.
REQ-015 protocol_err  out  1  sticky: issue seen without grant.

Function
REQ-016 States IDLE, FFT, NTT held in a register; fft_gnt = (state==FFT), ntt_gnt = (state==NTT), both registered-state decodes, never both high.
REQ-017 grant_to_fft SHALL be 1 in FFT, 0 in NTT, and hold its previous value in IDLE.
REQ-018 IDLE: one requester -> its state next cycle; both -> client not served last (reset history favours FFT); none -> stay.
REQ-019 FFT: !fft_req -> NTT if ntt_req else IDLE; fft_req && ntt_req && burst_cnt==MAX_BURST-1 -> NTT; else stay. NTT symmetric.
REQ-020 Direct FFT<->NTT switch SHALL occur with no idle bubble; in-flight results are unaffected.
REQ-021 burst_cnt (8 bit) SHALL clear on every state change and increment each cycle spent in FFT or NTT, saturating at MAX_BURST-1.
REQ-022 Accepted op: x_issue && x_gnt in cycle t -> x_res_valid high exactly in cycle t+MULT_LATENCY, one cycle per op.
REQ-023 Back-to-back accepted ops SHALL yield back-to-back res_valid pulses; throughput one op/cycle.
REQ-024 x_issue without x_gnt SHALL be dropped (no res_valid) and set protocol_err, cleared only by rst.
REQ-025 busy SHALL be high iff any delay-line stage holds a valid tag.
REQ-026 Simultaneous fft_issue and ntt_issue: only the granted one is accepted; the other sets protocol_err.

Reset
REQ-027 rst: state=IDLE, grant_to_fft=0, fft_gnt=ntt_gnt=0, burst_cnt=0, history=FFT-first, protocol_err=0, all delay-line tags cleared.
REQ-028 Reset mid-operation SHALL discard in-flight ops; no res_valid in the MULT_LATENCY cycles after rst deasserts unless newly issued.
REQ-029 Outputs during rst cycles SHALL equal reset values.

Structure
REQ-030 Shared package int_mult_pkg SHALL hold the state typedef (IDLE/FFT/NTT) and the default MULT_LATENCY constant, shared with the pool wrapper.
REQ-031 Sub-module tag_delay_line: MULT_LATENCY-deep 2-bit shift register {fft_valid, ntt_valid} with sync clear; busy = OR of stages.

Verification (MULT_LATENCY=6, MAX_BURST=4)
REQ-032 FFT only: fft_req=1 from cycle 0, fft_issue cycles 1..3 -> fft_gnt from cycle 1, fft_res_valid cycles 7..9, ntt_res_valid never.
REQ-033 Contention: both req held from cycle 0 -> FFT granted cycles 1..4, NTT 5..8, FFT 9..12; grant_to_fft tracks, no gap.
REQ-034 Switch with in-flight: FFT issues cycle 4, NTT issues cycle 5 -> fft_res_valid cycle 10, ntt_res_valid cycle 11, busy 5..11.
REQ-035 Illegal issue: ntt_issue in cycle 2 while FFT granted -> protocol_err from cycle 3 onward, no ntt_res_valid at cycle 8.
REQ-036 Reset mid-flight: FFT issues cycles 1..3, rst in cycle 4 -> no res_valid cycles 5..12, state IDLE, busy 0 from cycle 5.
REQ-037 Release: fft_req drops in cycle 3 with ntt_req=0 -> IDLE in cycle 4, grant_to_fft stays 1, gnts 0.
